wb_queue: RTL
=============

// Module: wb_queue
// PURPOSE
//  Write-side companion of the register file: buffers writeback results (e.g. from
//  multi-cycle load/ALU units) and drains them one per cycle into the register file's
//  single write port (we/a3/wd3). Provides youngest-match forwarding of pending writes
//  for two read addresses, so decode never reads a stale register value.
// PARAMETERS
//  WIDTH  32  data width, equal to register file WIDTH
//  DEPTH  4   queue entries; power of 2, >= 2
// PORTS
//  clk         in   1          rising-edge clock
//  rst         in   1          asynchronous, active-high reset
//  push_valid  in   1          producer has a writeback
//  push_ready  out  1          queue can accept (= !full)
//  push_rd     in   5          destination register
//  push_data   in   WIDTH      result value
//  drain_en    in   1          write port granted to queue this cycle
//  rf_we       out  1          to regfile we
//  rf_a3       out  5          to regfile a3
//  rf_wd3      out  WIDTH      to regfile wd3
//  q_a1,q_a2   in   5 each     read addresses to check against pending writes
//  hit1,hit2   out  1 each     pending write exists for q_a1 / q_a2
//  fwd1,fwd2   out  WIDTH each youngest pending data for q_a1 / q_a2
//  count       out  $clog2(DEPTH)+1  occupied entries
//  empty,full  out  1 each     count==0 / count==DEPTH
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, all entry valid bits 0;
//    outputs: rf_we=0, rf_a3=0, rf_wd3=0, hit*=0, fwd*=0, empty=1, full=0, push_ready=1.
//    Reset mid-operation discards all pending writes; none reach the register file.
//  - Push: accepted on edge when push_valid && push_ready. push_rd==0 is accepted
//    (handshake completes) but not stored; count unchanged.
//  - Drain: pop = !empty && drain_en. rf_we = pop (combinational), rf_a3/rf_wd3 = head
//    entry when pop, else 0. Regfile commits at the same edge the entry is popped.
//  - Latency: entry pushed at edge N is at head earliest in cycle N+1; regfile holds
//    value after edge N+1 if queue was empty and drain_en=1. Order strictly FIFO.
//  - Simultaneous push+pop (not full): count unchanged, both pointers advance.
//    When full, push_ready=0 even if a pop occurs this cycle (no pass-through).
//  - Pointers wrap modulo DEPTH; count saturates by construction (never >DEPTH, <0).
//  - Forwarding (combinational): scan valid stored entries; hitN=1 if any rd==q_aN and
//    q_aN!=0; fwdN = data of youngest (closest to wr_ptr) match, else 0. The entry being
//    popped this cycle still counts as pending; the same-cycle push does not.
//  - Multiple pending writes to one rd are all drained in order (WAW preserved).
// STRUCTURE
//  - Package wb_pkg: REG_ADDR_W=5; typedef struct packed {logic [4:0] rd;
//    logic [WIDTH-1:0] data;} wb_entry_t (WIDTH as package parameter = 32).
//  - Sub-module wb_fwd_match: one instance per read address; age-ordered priority
//    search over entry array, valid bits and wr_ptr -> hit/fwd.
//  - Top: entry array, pointers, count, handshake and drain logic.
// TESTING
//  1 Reset: assert rst while 3 entries pending -> count=0, empty=1, rf_we=0 immediately,
//    no regfile write after release.
//  2 Push rd=5,data=0xDEAD_BEEF with drain_en=1 -> next cycle rf_we=1,rf_a3=5,
//    rf_wd3=0xDEAD_BEEF; regfile x5 reads 0xDEAD_BEEF after that edge; empty=1 again.
//  3 drain_en=0, push 4 entries (rd=1..4) -> full=1, push_ready=0, 5th push held;
//    drain_en=1 -> writes rd 1,2,3,4 in order over 4 cycles, held push then accepted.
//  4 drain_en=0, push rd=7 data=0x11 then rd=7 data=0x22; q_a1=7 -> hit1=1,fwd1=0x22;
//    q_a2=0 -> hit2=0,fwd2=0; after draining both, hit1=0 and x7=0x22.
//  5 Push rd=0 data=0xFFFF_FFFF -> push_ready handshake completes, count stays 0,
//    rf_we never asserted, q_a1=0 gives hit1=0.
//  6 Continuous push+pop for 10 cycles (rd=1..10) -> count constant at 1, pointer
//    wrap exercised, regfile receives all 10 values in order.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//   Shared types and constants for the writeback queue.
//   - WIDTH       : register data width (must match the register file).
//   - REG_ADDR_W  : register address width (32 architectural registers).
//   - wb_entry_t  : one pending writeback {destination register, result}.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WIDTH      = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WIDTH-1:0]      data;
    } wb_entry_t;

endpackage : wb_pkg

// File: rtl/wb_fwd_match.sv
// -----------------------------------------------------------------------------
// wb_fwd_match
//   Youngest-match lookup of one read address against the pending writebacks.
//   Ports:
//     entries  in   stored entries, indexed by queue slot
//     valid    in   per-slot "holds a pending write" bits
//     wr_ptr   in   next slot to be written (slot wr_ptr-1 is the youngest)
//     q_a      in   read address to look up (x0 never matches)
//     hit      out  some valid entry targets q_a
//     fwd      out  data of the youngest such entry, 0 when no hit
// -----------------------------------------------------------------------------
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wb_entry_t              entries [DEPTH],
    input  logic [DEPTH-1:0]       valid,
    input  logic [PTR_W-1:0]       wr_ptr,
    input  logic [REG_ADDR_W-1:0]  q_a,
    output logic                   hit,
    output logic [WIDTH-1:0]       fwd
);

    logic [PTR_W-1:0] idx;

    // Walk slots from oldest (wr_ptr-DEPTH == wr_ptr) to youngest (wr_ptr-1);
    // a later match overwrites an earlier one, so the youngest write wins.
    // NOTE: every output of a combinational block gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        idx = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = wr_ptr - PTR_W'(i);
            if ((q_a != '0) && valid[idx] && (entries[idx].rd == q_a)) begin
                hit = 1'b1;
                fwd = entries[idx].data;
            end
        end
    end

endmodule : wb_fwd_match

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
//   Writeback buffer in front of the register file's single write port.
//   Results are queued in order and drained one per granted cycle; two read
//   addresses are checked against the pending writes so decode can forward
//   the youngest in-flight value instead of a stale register.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     push_valid/push_ready         producer handshake (ready = !full)
//     push_rd, push_data            destination register and result (rd 0 dropped)
//     drain_en                      write port granted to the queue this cycle
//     rf_we, rf_a3, rf_wd3          register file write port (head entry on pop)
//     q_a1/q_a2 -> hit1/2, fwd1/2   pending-write lookup for two read addresses
//     count, empty, full            occupancy status
//   WIDTH must equal wb_pkg::WIDTH (stored entries use the package type).
// -----------------------------------------------------------------------------
module wb_queue #(
    parameter int WIDTH = wb_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0] push_rd,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          drain_en,
    output logic                          rf_we,
    output logic [wb_pkg::REG_ADDR_W-1:0] rf_a3,
    output logic [WIDTH-1:0]              rf_wd3,
    input  logic [wb_pkg::REG_ADDR_W-1:0] q_a1,
    input  logic [wb_pkg::REG_ADDR_W-1:0] q_a2,
    output logic                          hit1,
    output logic                          hit2,
    output logic [WIDTH-1:0]              fwd1,
    output logic [WIDTH-1:0]              fwd2,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty,
    output logic                          full
);

    import wb_pkg::wb_entry_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    wb_entry_t        head;

    logic push_fire;
    logic store;
    logic pop;

    // Status. No pass-through when full: a same-cycle pop does not open the
    // queue for a push until the next cycle.
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign push_ready = !full;

    // A push to x0 completes the handshake but is dropped, since x0 is never written.
    assign push_fire = push_valid && push_ready;
    assign store     = push_fire && (push_rd != '0);
    assign pop       = !empty && drain_en;

    assign head   = entries[rd_ptr];
    assign rf_we  = pop;
    assign rf_a3  = pop ? head.rd   : '0;
    assign rf_wd3 = pop ? head.data : '0;

    // Control state. store and pop can never target the same slot: that would
    // need wr_ptr == rd_ptr with entries present, i.e. full, which blocks store.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (store) begin
                wr_ptr        <= wr_ptr + PTR_ONE;
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                valid[rd_ptr] <= 1'b0;
            end
            count <= count + CNT_W'(store) - CNT_W'(pop);
        end
    end

    // Entry payload storage.
    // NOTE: the payload array is deliberately not reset; the valid bits and
    // count qualify every use of it, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (store) begin
            entries[wr_ptr] <= '{rd: push_rd, data: push_data};
        end
    end

    // The slot being popped this cycle is still valid here, so it still
    // forwards; a same-cycle push is not yet stored, so it does not.
    wb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match1 (
        .entries (entries),
        .valid   (valid),
        .wr_ptr  (wr_ptr),
        .q_a     (q_a1),
        .hit     (hit1),
        .fwd     (fwd1)
    );

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match2 (
        .entries (entries),
        .valid   (valid),
        .wr_ptr  (wr_ptr),
        .q_a     (q_a2),
        .hit     (hit2),
        .fwd     (fwd2)
    );

endmodule : wb_queue
